// File: rtl/fml_arb_pkg.sv
// Shared definitions for the four-master FML arbiter: master count, burst
// length, bus widths and the transaction state encoding.
package fml_arb_pkg;

    localparam int NMASTERS  = 4;
    localparam int BURST_LEN = 4;
    localparam int DATA_W    = 64;
    localparam int SEL_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/fml_arb_pick.sv
// Combinational winner selection for the FML arbiter.
// Searches the 4-bit request vector starting at 'start' and wrapping around;
// the first set bit found is the winner. 'valid' is low when nothing is requested.
module fml_arb_pick
    import fml_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester is assigned last
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 2'd0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end else begin
                winner = winner;
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/fml_arb.sv
// Four-master arbiter in front of an FML slave (SDRAM controller).
// Each transaction is one address phase (held until the slave acks) followed
// by a fixed four-beat data phase. Read data is broadcast to every master.
// Optional feature: define FML_ARB_ROUNDROBIN_EN for round-robin arbitration;
// without it master 0 has the highest and master 3 the lowest priority.
module fml_arb
    import fml_arb_pkg::*;
#(
    parameter int fml_depth = 26,
    parameter int burst_len = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,

    input  logic [NMASTERS*fml_depth-1:0] m_adr,
    input  logic [NMASTERS-1:0]           m_stb,
    input  logic [NMASTERS-1:0]           m_we,
    input  logic [NMASTERS*SEL_W-1:0]     m_sel,
    input  logic [NMASTERS*DATA_W-1:0]    m_do,
    output logic [NMASTERS-1:0]           m_ack,
    output logic [DATA_W-1:0]             m_di,

    output logic [fml_depth-1:0]          s_adr,
    output logic                          s_stb,
    output logic                          s_we,
    input  logic                          s_ack,
    output logic [SEL_W-1:0]              s_sel,
    output logic [DATA_W-1:0]             s_do,
    input  logic [DATA_W-1:0]             s_di
);

    // The data phase is fixed at four beats in this revision; the counter is 2 bits.
    localparam int         BEATS     = (burst_len == BURST_LEN) ? burst_len : BURST_LEN;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t     state_r;
    state_t     state_nxt;
    logic [1:0] grant_r;
    logic [1:0] grant_nxt;
    logic [1:0] owner_r;
    logic [1:0] owner_nxt;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt;

    logic [1:0] pick_start;
    logic [1:0] pick_winner;
    logic       pick_valid;
    logic [1:0] route_s;

`ifdef FML_ARB_ROUNDROBIN_EN
    logic [1:0] ptr_r;
    logic [1:0] ptr_nxt;

    assign pick_start = ptr_r;

    // Pointer moves just past the winner whenever a grant is issued
    always_comb begin
        ptr_nxt = ptr_r;
        if ((state_r == IDLE) && pick_valid) begin
            ptr_nxt = pick_winner + 2'd1;
        end else begin
            ptr_nxt = ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_r <= 2'd0;
        end else begin
            ptr_r <= ptr_nxt;
        end
    end
`else
    assign pick_start = 2'd0;
`endif

    fml_arb_pick u_pick (
        .req    (m_stb),
        .start  (pick_start),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Next-state logic: arbitrate in IDLE, hold grant until ack, count four beats
    always_comb begin
        state_nxt = state_r;
        grant_nxt = grant_r;
        owner_nxt = owner_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = ADDR;
                    grant_nxt = pick_winner;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ADDR: begin
                if (s_ack) begin
                    state_nxt = DATA;
                    cnt_nxt   = 2'd0;
                    owner_nxt = grant_r;
                end else begin
                    state_nxt = ADDR;
                end
            end
            DATA: begin
                if (cnt_r == LAST_BEAT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = cnt_r;
                end else begin
                    state_nxt = DATA;
                    cnt_nxt   = cnt_r + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Transaction state registers; reset aborts any transaction in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
            grant_r <= 2'd0;
            owner_r <= 2'd0;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt;
            grant_r <= grant_nxt;
            owner_r <= owner_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // Write data follows the latched owner during the burst, the grant otherwise
    always_comb begin
        route_s = grant_r;
        if (state_r == DATA) begin
            route_s = owner_r;
        end else begin
            route_s = grant_r;
        end
    end

    // Slave-side address/data muxes and strobe
    always_comb begin
        s_stb = (state_r == ADDR);
        s_adr = m_adr[int'(grant_r) * fml_depth +: fml_depth];
        s_we  = m_we[grant_r];
        s_do  = m_do[int'(route_s) * DATA_W +: DATA_W];
        s_sel = m_sel[int'(route_s) * SEL_W +: SEL_W];
    end

    // Slave ack is passed only to the granted master during the address phase
    always_comb begin
        m_ack = 4'd0;
        if ((state_r == ADDR) && s_ack) begin
            m_ack[grant_r] = 1'b1;
        end else begin
            m_ack = 4'd0;
        end
    end

    // Read data is broadcast to all masters without latency
    always_comb begin
        m_di = s_di;
    end

endmodule

// File: tb/tb_fml_arb.sv
`timescale 1ns/1ps
module tb_fml_arb;

    localparam int FD = 26;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic [4*FD-1:0] m_adr;
    logic [3:0]     m_stb;
    logic [3:0]     m_we;
    logic [31:0]    m_sel;
    logic [255:0]   m_do;
    logic [3:0]     m_ack;
    logic [63:0]    m_di;
    logic [FD-1:0]  s_adr;
    logic           s_stb;
    logic           s_we;
    logic           s_ack;
    logic [7:0]     s_sel;
    logic [63:0]    s_do;
    logic [63:0]    s_di;

    int errors = 0;
    int checks = 0;

    // Observations collected by run_txn for the calling test to judge
    logic           o_idle_stb;
    logic [3:0]     o_idle_ack;
    logic           o_addr_stb;
    logic [3:0]     o_early_ack;
    logic           o_ack_stb;
    logic [3:0]     o_ack_ack;
    logic [FD-1:0]  o_adr;
    logic           o_we;
    logic [63:0]    o_addr_do;
    logic [7:0]     o_addr_sel;
    logic           o_data_stb;
    logic [3:0]     o_data_ack;
    logic [63:0]    o_do [4];
    logic [7:0]     o_sel [4];
    logic [255:0]   d_addr_do;
    logic [31:0]    d_addr_sel;
    logic [255:0]   d_do [4];
    logic [31:0]    d_sel [4];
    int             o_di_bad;

`ifdef FML_ARB_ROUNDROBIN_EN
    int model_ptr = 0;
`endif

    fml_arb #(.fml_depth(FD), .burst_len(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m_adr     (m_adr),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_do      (m_do),
        .m_ack     (m_ack),
        .m_di      (m_di),
        .s_adr     (s_adr),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_ack     (s_ack),
        .s_sel     (s_sel),
        .s_do      (s_do),
        .s_di      (s_di)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference arbitration: first requester at or after the search base
    function automatic int exp_winner(input logic [3:0] req);
        int base;
        base = 0;
`ifdef FML_ARB_ROUNDROBIN_EN
        base = model_ptr;
`endif
        for (int k = 0; k < 4; k++) begin
            if (req[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic note_grant(input int w);
`ifdef FML_ARB_ROUNDROBIN_EN
        model_ptr = (w + 1) % 4;
`else
        if (w < 0) $display("note: grant with no request");
`endif
    endtask

    task automatic model_reset();
`ifdef FML_ARB_ROUNDROBIN_EN
        model_ptr = 0;
`endif
    endtask

    task automatic rand_bus();
        m_adr = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_do  = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        m_sel = $urandom();
        m_we  = 4'($urandom());
    endtask

    // Drives one transaction from an IDLE cycle: slave acks after ack_delay
    // address cycles, next_stb is applied at data beat 1, masters not in keep
    // get fresh write data every beat. Entered and left at posedge+1 in IDLE.
    task automatic run_txn(input int ack_delay, input logic [3:0] next_stb, input logic [3:0] keep);
        o_di_bad = 0;
        s_ack = 1'($urandom());
        s_di = {$urandom(), $urandom()};
        #4;
        o_idle_stb = s_stb;
        o_idle_ack = m_ack;
        if (m_di !== s_di) o_di_bad++;
        @(posedge sys_clk); #1;
        s_ack = 1'b0;
        o_addr_stb  = 1'b1;
        o_early_ack = 4'd0;
        for (int d = 0; d < ack_delay; d++) begin
            s_di = {$urandom(), $urandom()};
            #4;
            o_addr_stb  = o_addr_stb & s_stb;
            o_early_ack = o_early_ack | m_ack;
            if (m_di !== s_di) o_di_bad++;
            @(posedge sys_clk); #1;
        end
        s_ack = 1'b1;
        #4;
        o_ack_stb  = s_stb;
        o_ack_ack  = m_ack;
        o_adr      = s_adr;
        o_we       = s_we;
        o_addr_do  = s_do;
        o_addr_sel = s_sel;
        d_addr_do  = m_do;
        d_addr_sel = m_sel;
        @(posedge sys_clk); #1;
        o_data_stb = 1'b0;
        o_data_ack = 4'd0;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) m_stb = next_stb;
            for (int i = 0; i < 4; i++) begin
                if (!keep[i]) begin
                    m_do[i*64 +: 64] = {$urandom(), $urandom()};
                    m_sel[i*8 +: 8]  = 8'($urandom());
                end
            end
            d_do[b]  = m_do;
            d_sel[b] = m_sel;
            s_ack = 1'($urandom());
            s_di  = {$urandom(), $urandom()};
            #4;
            o_do[b]    = s_do;
            o_sel[b]   = s_sel;
            o_data_stb = o_data_stb | s_stb;
            o_data_ack = o_data_ack | m_ack;
            if (m_di !== s_di) o_di_bad++;
            @(posedge sys_clk); #1;
        end
        s_ack = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        m_stb = 4'd0;
        s_ack = 1'b0;
        s_di  = 64'd0;
        rand_bus();
        #3;
        checks++; if (s_stb !== 1'b0 || m_ack !== 4'd0) begin errors++; $display("FAIL reset_idle got stb=%b ack=%b want 0/0000", s_stb, m_ack); end
        checks++; if (s_adr !== m_adr[FD-1:0] || s_do !== m_do[63:0]) begin errors++; $display("FAIL reset_grant0 got adr=%h do=%h want %h/%h", s_adr, s_do, m_adr[FD-1:0], m_do[63:0]); end
        m_stb = 4'b0100;
        @(posedge sys_clk); #1;
        checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_hold got stb=%b want 0", s_stb); end
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        checks++; if (s_stb !== 1'b1 || s_adr !== m_adr[2*FD +: FD]) begin errors++; $display("FAIL reset_first_edge got stb=%b adr=%h want 1/%h", s_stb, s_adr, m_adr[2*FD +: FD]); end
        sys_rst_n = 1'b0;
        #1;
        checks++; if (s_stb !== 1'b0 || s_adr !== m_adr[FD-1:0]) begin errors++; $display("FAIL reset_async got stb=%b adr=%h want 0/%h", s_stb, s_adr, m_adr[FD-1:0]); end
        m_stb = 4'd0;
        #2 sys_rst_n = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'($urandom());
            #4;
            checks++; if (s_stb !== 1'b0 || m_ack !== 4'd0) begin errors++; $display("FAIL idle_quiet got stb=%b ack=%b want 0/0000", s_stb, m_ack); end
            @(posedge sys_clk); #1;
        end
        s_ack = 1'b0;
    endtask

    task automatic test_broadcast();
        logic [63:0] pat;
        pat  = 64'h0123456789ABCDEF;
        s_di = pat;
        #1;
        checks++; if (m_di !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL broadcast_pat got %h want %h", m_di, pat); end
        s_di = ~pat;
        #1;
        checks++; if (m_di !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL broadcast_inv got %h want %h", m_di, ~pat); end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_single_read();
        int bad;
        m_adr[FD +: FD] = 26'h0000100;
        m_we  = 4'b0000;
        m_stb = 4'b0010;
        note_grant(exp_winner(m_stb));
        run_txn(3, 4'b0000, 4'b0000);
        checks++; if (o_idle_stb !== 1'b0) begin errors++; $display("FAIL read_idle got stb=%b want 0", o_idle_stb); end
        checks++; if (o_addr_stb !== 1'b1 || o_ack_stb !== 1'b1 || o_early_ack !== 4'd0) begin errors++; $display("FAIL read_addr got stb=%b/%b early=%b want 1/1/0000", o_addr_stb, o_ack_stb, o_early_ack); end
        checks++; if (o_ack_ack !== 4'b0010) begin errors++; $display("FAIL read_ack got %b want 0010", o_ack_ack); end
        checks++; if (o_adr !== 26'h0000100 || o_we !== 1'b0) begin errors++; $display("FAIL read_adr got %h we=%b want 0000100/0", o_adr, o_we); end
        checks++; if (o_data_stb !== 1'b0 || o_data_ack !== 4'd0) begin errors++; $display("FAIL read_data_quiet got stb=%b ack=%b want 0/0000", o_data_stb, o_data_ack); end
        bad = 0;
        for (int b = 0; b < 4; b++) if (o_do[b] !== d_do[b][64 +: 64] || o_sel[b] !== d_sel[b][8 +: 8]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL read_routing got %0d bad beats want 0", bad); end
        checks++; if (o_di_bad != 0) begin errors++; $display("FAIL read_di got %0d bad samples want 0", o_di_bad); end
        #4;
        checks++; if (s_stb !== 1'b0 || m_ack !== 4'd0) begin errors++; $display("FAIL read_back_idle got stb=%b ack=%b want 0/0000", s_stb, m_ack); end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_write_routing();
        int bad;
        m_do[2*64 +: 64] = 64'hDEADBEEF_00000001;
        m_sel[2*8 +: 8]  = 8'h0F;
        m_we  = 4'b0100;
        m_stb = 4'b0100;
        note_grant(exp_winner(m_stb));
        run_txn(0, 4'b0000, 4'b0100);
        checks++; if (o_ack_ack !== 4'b0100 || o_we !== 1'b1) begin errors++; $display("FAIL write_ack got %b we=%b want 0100/1", o_ack_ack, o_we); end
        checks++; if (o_addr_do !== 64'hDEADBEEF_00000001 || o_addr_sel !== 8'h0F) begin errors++; $display("FAIL write_addr_data got %h/%h want deadbeef00000001/0f", o_addr_do, o_addr_sel); end
        bad = 0;
        for (int b = 0; b < 4; b++) if (o_do[b] !== 64'hDEADBEEF_00000001 || o_sel[b] !== 8'h0F) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL write_routing got %0d bad beats want 0", bad); end
    endtask

    task automatic test_late_request();
        m_stb = 4'b0001;
        note_grant(exp_winner(m_stb));
        run_txn(0, 4'b1000, 4'b0000);
        checks++; if (o_ack_ack !== 4'b0001) begin errors++; $display("FAIL late_first_ack got %b want 0001", o_ack_ack); end
        note_grant(exp_winner(m_stb));
        run_txn(1, 4'b0000, 4'b0000);
        checks++; if (o_idle_stb !== 1'b0) begin errors++; $display("FAIL late_idle got stb=%b want 0", o_idle_stb); end
        checks++; if (o_addr_stb !== 1'b1) begin errors++; $display("FAIL late_stb_next got stb=%b want 1", o_addr_stb); end
        checks++; if (o_ack_ack !== 4'b1000 || o_adr !== m_adr[3*FD +: FD]) begin errors++; $display("FAIL late_grant got %b adr=%h want 1000/%h", o_ack_ack, o_adr, m_adr[3*FD +: FD]); end
    endtask

    task automatic test_reset_mid_burst();
        m_stb = 4'b0010;
        note_grant(exp_winner(m_stb));
        s_di = 64'h0123456789ABCDEF;
        @(posedge sys_clk); #1;
        s_ack = 1'b1;
        @(posedge sys_clk); #1;
        s_ack = 1'b0;
        m_stb = 4'b0000;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        #2 sys_rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        checks++; if (s_stb !== 1'b0 || m_ack !== 4'd0) begin errors++; $display("FAIL midreset_quiet got stb=%b ack=%b want 0/0000", s_stb, m_ack); end
        checks++; if (s_do !== m_do[63:0] || m_di !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL midreset_mux got do=%h di=%h want %h/0123456789abcdef", s_do, m_di, m_do[63:0]); end
        @(posedge sys_clk); #1;
        checks++; if (s_stb !== 1'b0 || m_ack !== 4'd0) begin errors++; $display("FAIL midreset_held got stb=%b ack=%b want 0/0000", s_stb, m_ack); end
        m_stb = 4'b0100;
        s_ack = 1'b0;
        #2 sys_rst_n = 1'b1;
        model_reset();
        note_grant(exp_winner(m_stb));
        run_txn(1, 4'b0000, 4'b0000);
        checks++; if (o_idle_stb !== 1'b0 || o_ack_ack !== 4'b0100) begin errors++; $display("FAIL midreset_regrant got stb=%b ack=%b want 0/0100", o_idle_stb, o_ack_ack); end
    endtask

    task automatic test_contention();
        int want;
        sys_rst_n = 1'b0;
        #1 sys_rst_n = 1'b1;
        model_reset();
        m_stb = 4'hF;
        for (int t = 0; t < 8; t++) begin
`ifdef FML_ARB_ROUNDROBIN_EN
            want = t % 4;
`else
            want = 0;
`endif
            note_grant(exp_winner(m_stb));
            run_txn(int'($urandom_range(0, 2)), (t == 7) ? 4'h0 : 4'hF, 4'b0000);
            checks++; if (o_ack_ack !== (4'd1 << want) || o_adr !== m_adr[want*FD +: FD]) begin errors++; $display("FAIL contention_%0d got ack=%b want %b", t, o_ack_ack, 4'd1 << want); end
        end
    endtask

    task automatic test_random();
        int w;
        int bad;
        logic [3:0] nxt;
        m_stb = 4'($urandom_range(1, 15));
        for (int t = 0; t < 24; t++) begin
            m_adr = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_we  = 4'($urandom());
            w = exp_winner(m_stb);
            note_grant(w);
            nxt = (t == 23) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(int'($urandom_range(0, 3)), nxt, 4'b0000);
            checks++; if (o_idle_stb !== 1'b0 || o_idle_ack !== 4'd0) begin errors++; $display("FAIL rand_idle_%0d got stb=%b ack=%b want 0/0000", t, o_idle_stb, o_idle_ack); end
            checks++; if (o_addr_stb !== 1'b1 || o_ack_stb !== 1'b1 || o_early_ack !== 4'd0) begin errors++; $display("FAIL rand_addr_%0d got stb=%b/%b early=%b want 1/1/0000", t, o_addr_stb, o_ack_stb, o_early_ack); end
            checks++; if (o_ack_ack !== (4'd1 << w)) begin errors++; $display("FAIL rand_grant_%0d got %b want %b", t, o_ack_ack, 4'd1 << w); end
            checks++; if (o_adr !== m_adr[w*FD +: FD] || o_we !== m_we[w]) begin errors++; $display("FAIL rand_adr_%0d got %h/%b want %h/%b", t, o_adr, o_we, m_adr[w*FD +: FD], m_we[w]); end
            checks++; if (o_addr_do !== d_addr_do[w*64 +: 64] || o_addr_sel !== d_addr_sel[w*8 +: 8]) begin errors++; $display("FAIL rand_addr_data_%0d got %h/%h want %h/%h", t, o_addr_do, o_addr_sel, d_addr_do[w*64 +: 64], d_addr_sel[w*8 +: 8]); end
            bad = 0;
            for (int b = 0; b < 4; b++) if (o_do[b] !== d_do[b][w*64 +: 64] || o_sel[b] !== d_sel[b][w*8 +: 8]) bad++;
            checks++; if (bad != 0 || o_data_stb !== 1'b0 || o_data_ack !== 4'd0) begin errors++; $display("FAIL rand_data_%0d got %0d bad beats stb=%b ack=%b want 0/0/0000", t, bad, o_data_stb, o_data_ack); end
            checks++; if (o_di_bad != 0) begin errors++; $display("FAIL rand_di_%0d got %0d bad samples want 0", t, o_di_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_broadcast();
        test_single_read();
        test_write_routing();
        test_late_request();
        test_reset_mid_burst();
        test_contention();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
